// File: rtl/wsat_pkg.sv
// Shared definitions for the WalkSAT table loader.
// Contents:
//   target_e       - header target codes, including the END marker
//   Hdr*           - bit positions of the header word fields
//   Wr*            - bit index of each table in the one-hot write strobe
//   state_e        - loader FSM states
//   tgt_strobe()   - target code to one-hot write strobe
package wsat_pkg;

  // Header target codes. Codes 5..14 are unassigned and flag an error.
  typedef enum logic [3:0] {
    TgtAtAddr = 4'd0,
    TgtAtMask = 4'd1,
    TgtClause = 4'd2,
    TgtVar    = 4'd3,
    TgtUcb    = 4'd4,
    TgtEnd    = 4'hF
  } target_e;

  // Header layout: [35:32] target, [31:20] start address, [11:0] payload count.
  localparam int unsigned HdrTgtMsb  = 35;
  localparam int unsigned HdrTgtLsb  = 32;
  localparam int unsigned HdrAddrMsb = 31;
  localparam int unsigned HdrAddrLsb = 20;
  localparam int unsigned HdrCntMsb  = 11;
  localparam int unsigned HdrCntLsb  = 0;
  localparam int unsigned CntW       = 12;

  // Write-strobe bit assignment.
  localparam int unsigned NumTables = 5;
  localparam int unsigned WrAtAddr  = 0;
  localparam int unsigned WrAtMask  = 1;
  localparam int unsigned WrClause  = 2;
  localparam int unsigned WrVar     = 3;
  localparam int unsigned WrUcb     = 4;

  typedef enum logic [2:0] {
    StHdr,
    StData,
    StUnpack,
    StSkip,
    StBoot
  } state_e;

  // Decode a known table target into its write strobe; anything else gives no strobe.
  function automatic logic [NumTables-1:0] tgt_strobe(input logic [3:0] tgt);
    logic [NumTables-1:0] s;
    s = '0;
    unique case (tgt)
      TgtAtAddr: s[WrAtAddr] = 1'b1;
      TgtAtMask: s[WrAtMask] = 1'b1;
      TgtClause: s[WrClause] = 1'b1;
      TgtVar:    s[WrVar]    = 1'b1;
      TgtUcb:    s[WrUcb]    = 1'b1;
      default:   s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bit_unpacker.sv
// Serialises one packed variable-table word into single truth-value bits.
// The loader writes bit 0 itself in the cycle the word is accepted, so the
// shift register keeps the remaining VBITS-1 bits and counts them out.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture load_data (bit 0 is consumed by the caller)
//   load_data  - packed truth values, LSB first
//   step       - consume the current bit (ignored once done)
//   bit_out    - current bit to write
//   done       - no bits left
module bit_unpacker
  import wsat_pkg::*;
#(
  parameter int unsigned VBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VBITS-1:0] load_data,
  input  logic             step,
  output logic             bit_out,
  output logic             done
);

  localparam int unsigned RemW = $clog2(VBITS + 1);

  logic [VBITS-1:0] shreg_q, shreg_d;
  logic [RemW-1:0]  remain_q, remain_d;

  assign bit_out = shreg_q[0];
  assign done    = (remain_q == '0);

  always_comb begin
    shreg_d  = shreg_q;
    remain_d = remain_q;
    if (load) begin
      shreg_d  = load_data >> 1;
      remain_d = RemW'(VBITS - 1);
    end else if (step && !done) begin
      shreg_d  = shreg_q >> 1;
      remain_d = remain_q - RemW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      remain_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      remain_q <= remain_d;
    end
  end

endmodule

// File: rtl/table_loader.sv
// Stream-driven writer that fills the WalkSAT solver tables (AT address,
// AT mask, clause table, variable truth values, UCB) from a header/payload
// word stream, then pulses boot and enables the solver core.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - stream handshake; in_data is a header or payload word
//   wr_en               - registered one-hot table write strobe
//   wr_addr, wr_data    - registered write address and zero-extended data
//   boot                - one-cycle load-complete pulse
//   reg_en              - solver enable level
//   busy                - FSM is not waiting for a header
//   err                 - sticky unknown-target flag
module table_loader
  import wsat_pkg::*;
#(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned VBITS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [4:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              boot,
  output logic              reg_en,
  output logic              busy,
  output logic              err
);

  state_e            state_q, state_d;
  logic [3:0]        tgt_q, tgt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [4:0]        wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              boot_q, boot_d;
  logic              reg_en_q, reg_en_d;
  logic              err_q, err_d;

  logic              accept;
  logic [3:0]        hdr_tgt;
  logic [ADDR_W-1:0] hdr_addr;
  logic [CntW-1:0]   hdr_cnt;

  logic              unpack_load;
  logic              unpack_step;
  logic              unpack_bit;
  logic              unpack_done;

  assign in_ready = !rst && (state_q inside {StHdr, StData, StSkip});
  assign accept   = in_valid && in_ready;

  assign hdr_tgt  = in_data[HdrTgtMsb:HdrTgtLsb];
  assign hdr_addr = ADDR_W'(in_data[HdrAddrMsb:HdrAddrLsb]);
  assign hdr_cnt  = in_data[HdrCntMsb:HdrCntLsb];

  bit_unpacker #(
    .VBITS (VBITS)
  ) u_bit_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load      (unpack_load),
    .load_data (in_data[VBITS-1:0]),
    .step      (unpack_step),
    .bit_out   (unpack_bit),
    .done      (unpack_done)
  );

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_en_d     = '0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    boot_d      = 1'b0;
    // Enable rises the cycle after the boot pulse and holds until cleared below.
    reg_en_d    = reg_en_q || boot_q;
    err_d       = err_q;
    unpack_load = 1'b0;
    unpack_step = 1'b0;

    unique case (state_q)
      StHdr: begin
        if (accept) begin
          if (hdr_tgt == TgtEnd) begin
            boot_d   = 1'b1;
            reg_en_d = 1'b0;
            state_d  = StBoot;
          end else begin
            if (hdr_tgt > TgtUcb) begin
              err_d = 1'b1;
            end
            if (hdr_cnt != '0) begin
              reg_en_d = 1'b0;
              tgt_d    = hdr_tgt;
              cnt_d    = hdr_cnt;
              addr_d   = hdr_addr;
              state_d  = (hdr_tgt > TgtUcb) ? StSkip : StData;
            end
          end
        end
      end

      StData: begin
        if (accept) begin
          cnt_d     = cnt_q - CntW'(1);
          addr_d    = addr_q + ADDR_W'(1);
          wr_addr_d = addr_q;
          wr_en_d   = tgt_strobe(tgt_q);
          if (tgt_q == TgtVar) begin
            // Bit 0 goes out now; the unpacker supplies the rest.
            wr_data_d    = '0;
            wr_data_d[0] = in_data[0];
            unpack_load  = 1'b1;
            state_d      = StUnpack;
          end else begin
            wr_data_d = in_data;
            if (cnt_q == CntW'(1)) begin
              state_d = StHdr;
            end
          end
        end
      end

      StUnpack: begin
        if (!unpack_done) begin
          unpack_step  = 1'b1;
          wr_en_d      = tgt_strobe(TgtVar);
          wr_addr_d    = addr_q;
          wr_data_d    = '0;
          wr_data_d[0] = unpack_bit;
          addr_d       = addr_q + ADDR_W'(1);
        end else begin
          // cnt_q was already decremented when the word was accepted.
          state_d = (cnt_q == '0) ? StHdr : StData;
        end
      end

      StSkip: begin
        if (accept) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StHdr;
          end
        end
      end

      StBoot: begin
        state_d = StHdr;
      end

      default: begin
        state_d = StHdr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHdr;
      tgt_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      boot_q    <= 1'b0;
      reg_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      boot_q    <= boot_d;
      reg_en_q  <= reg_en_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign boot    = boot_q;
  assign reg_en  = reg_en_q;
  assign err     = err_q;
  assign busy    = (state_q != StHdr);

endmodule

// File: doc/table_loader.md
# table_loader

Stream-driven writer that fills the WalkSAT solver tables: address table, mask table, clause table, variable truth values and unsatisfied-clause buffer. It is the front-door replacement for backdoor memory preloading. It sits between the host input stream and the write ports of the table memories. After the final table it pulses `boot` and then raises `reg_en` for the solver core.

## Interface
Parameters:
- `DATA_W`, 36: stream word and write-data width (clause table word width)
- `ADDR_W`, 12: table write-address width
- `VBITS`, 32: truth values packed per variable-table payload word

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  stream word valid
- `in_ready`  out  1  loader accepts word this cycle
- `in_data`  in  DATA_W  header or payload word
- `wr_en`  out  5  one-hot write strobe: [0] AT address, [1] AT mask, [2] clause table, [3] var value, [4] UCB
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  DATA_W  write data, zero-extended; var writes use bit 0 only
- `boot`  out  1  one-cycle load-complete pulse
- `reg_en`  out  1  solver enable, level
- `busy`  out  1  high in any state other than HDR
- `err`  out  1  sticky unknown-target flag

## Operation
- Header word fields:
  - [35:32] target: 0 AT address, 1 AT mask, 2 clause, 3 var, 4 UCB, 0xF END
  - [31:20] start address
  - [11:0] payload word count N
- FSM states: HDR, DATA, UNPACK, SKIP, BOOT.
- HDR: `in_ready`=1. On accepted header:
  - target 0–4, N>0: latch target/address/count, go to DATA.
  - N=0: no writes, stay in HDR.
  - END: go to BOOT.
  - Targets 5–14: set `err`; N>0 goes to SKIP, N=0 stays in HDR.
- DATA: `in_ready`=1. Each accepted word issues one write and increments the address.
  - Targets 0, 1, 2, 4: `wr_data` = word (truncation happens at the sink).
  - Target 3: latch word, deassert `in_ready`, go to UNPACK.
  - After the Nth word, return to HDR.
- UNPACK: `in_ready`=0. Emits VBITS consecutive var writes, LSB first, address +1 each.
  - After the last bit: go to DATA, or to HDR if this was the Nth word.
- SKIP: `in_ready`=1. Consumes N words, no writes, then returns to HDR.
- BOOT: `in_ready`=0. For one cycle `boot`=1 and `reg_en` is cleared, then go to HDR.
  - `reg_en` sets the cycle after the `boot` pulse.
  - `reg_en` clears on the next accepted non-END header with N>0, or on `rst`.
- Address arithmetic is modulo 2^ADDR_W; wrap from 0xFFF to 0x000 is silent.
- `in_data` is ignored when `in_valid`=0; the FSM holds.

## Timing
- Write outputs are registered: an accepted word in DATA produces `wr_en`/`wr_addr`/`wr_data` on the next cycle.
- UNPACK writes occur on consecutive cycles, the first one cycle after the var word is accepted.
- Throughput:
  - Tables 0, 1, 2, 4: one word per cycle.
  - Var table: 1 word per VBITS+1 cycles.
- `wr_en` is zero on any cycle with no write. At most one bit of `wr_en` is ever set.
- `boot` is high exactly one cycle, one cycle after END is accepted.
- Reset values: `in_ready`=0 during reset, 1 the first cycle after; all other outputs are 0. State returns to HDR.
- Reset mid-load abandons the partial transfer. Writes already issued stand.

## Structure
- Package `wsat_pkg`:
  - target enum and END code
  - header field bit positions
  - write-strobe index constants
  - FSM state typedef
- Sub-module `bit_unpacker`: shift register plus bit counter with a load/step/done handshake, instantiated for UNPACK.
- Counters: payload count (12 bits) and write address (ADDR_W).

## Test plan
- Header {0, 0x001, N=3}, payloads 0x20, 0x30, 0x40:
  - Expect `wr_en`=00001 at addresses 1, 2, 3 with those data.
  - Each write lands one cycle after acceptance.
- Header {3, 0x000, N=2}, payloads 0x0000_0005, 0x8000_0000:
  - Expect 64 var writes; addresses 0 and 2 carry 1, address 63 carries 1, all others 0.
  - `in_ready` is low for 32 cycles after each word.
- Header {2, 0xFFE, N=4}: expect writes at 0xFFE, 0xFFF, 0x000, 0x001.
- Header {7, 0, N=2}, two words, then {4, 5, N=1}:
  - `err`=1, the first two payloads produce no writes, and the UCB write lands at address 5.
- Load several tables, then END:
  - `boot` is high exactly one cycle and `reg_en` rises the next cycle.
  - A new header {1, 0, N=1} clears `reg_en`.
- Assert `rst` midway through UNPACK:
  - Next cycle all outputs are 0 and state is HDR.
  - A fresh header is accepted normally.
- Throughout: `in_valid` toggled randomly, checking that no word is lost or duplicated.
